pos_pkt_receiver: RTL
=====================

Name: pos_pkt_receiver

Overview:
- Consumer end of the position-cache broadcast stream.
- One instance per home cell. It accepts position packets with their source global cell ID, and drops any packet whose source is not in the home cell's 27-cell neighbourhood (with wrap-around).
- It tags each kept packet with a neighbour slot index and buffers it in a show-ahead FIFO for the force PEs.
- It tracks per-source completion and signals iteration done once every source has finished and the FIFO has drained.

Parameters:
- PKT_WIDTH, 64, width of the position packet payload.
- GCID_WIDTH, 3, width of one dimension of a global cell ID.
- CELLS_X, 4, cell count in X (wrap modulus).
- CELLS_Y, 4, cell count in Y (wrap modulus).
- CELLS_Z, 4, cell count in Z (wrap modulus).
- FIFO_DEPTH, 16, buffer entries; power of two, at least 2.
- NUM_SRC, 8, number of source caches feeding done flags.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_PE_start  in  1  one-cycle pulse that starts an iteration.
- i_home_gcid  in  3*GCID_WIDTH  home cell {x,y,z}; static during an iteration.
- i_pos_pkt  in  PKT_WIDTH  incoming position packet.
- i_cur_gcid  in  3*GCID_WIDTH  source cell {x,y,z} of i_pos_pkt.
- i_valid  in  1  input packet valid.
- o_ready  out  1  receiver can accept a packet.
- i_src_done  in  NUM_SRC  per-source pulse: that source has finished streaming.
- o_pkt  out  PKT_WIDTH  FIFO head packet.
- o_nb_slot  out  5  neighbour slot of the head packet, 0..26.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  downstream accepts the head.
- o_iter_done  out  1  one-cycle pulse at iteration end.
- o_accept_cnt  out  16  packets accepted this iteration; saturates at 0xFFFF.
- o_drop_cnt  out  16  packets dropped this iteration; saturates at 0xFFFF.
- o_debug_state  out  2  current FSM state.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State = IDLE.
  - FIFO empty; read and write pointers = 0.
  - Done mask = 0.
  - All outputs = 0.
- FSM encoding: IDLE=0, RECV=1, DRAIN=2, DONE=3.
  - IDLE: on i_PE_start, go to RECV. On that same edge, clear the done mask, o_accept_cnt and o_drop_cnt.
  - RECV: when (done mask | i_src_done) equals all ones, go to DRAIN.
  - DRAIN: when the FIFO is empty, go to DONE.
  - DONE: assert o_iter_done for exactly one cycle, then go to IDLE.
  - i_PE_start outside IDLE is ignored.
- Done mask: sticky OR of i_src_done. It is updated only in RECV; pulses arriving in other states are ignored.
- o_ready = (state==RECV) && !full. It is a combinational function of registered state only.
- A handshake occurs when i_valid && o_ready on a rising edge. For each handshake:
  - Compute d = (src - home) mod CELLS, separately for each dimension, using unsigned arithmetic at GCID_WIDTH+1 bits before the modulo.
  - Map each d to a signed offset: d==0 → 0, d==1 → +1, d==CELLS-1 → -1, any other d → not a neighbour.
  - If any dimension is not a neighbour, drop the packet: no FIFO write, o_drop_cnt += 1.
  - Otherwise, push {pkt, slot} with slot = (ox+1)*9 + (oy+1)*3 + (oz+1), and o_accept_cnt += 1.
  - When CELLS==2, offsets +1 and -1 are the same cell; the +1 mapping wins.
- FIFO:
  - Show-ahead: o_valid = !empty; o_pkt and o_nb_slot come from the head entry.
  - Pop on o_valid && i_ready.
  - Push-to-output latency is 1 cycle: a packet written at edge N is visible after edge N.
  - Simultaneous push and pop are allowed when not full or when empty; occupancy stays unchanged.
  - Full blocks pushes through o_ready. A pop while full frees the slot for the next cycle; there is no same-cycle refill.
  - Pointers wrap modulo FIFO_DEPTH. A count register tracks occupancy, range 0..FIFO_DEPTH.
- The FIFO keeps popping in all states, so the downstream may drain during RECV.
- If all sources are already done on the i_PE_start cycle of the next iteration, the block still goes through RECV for at least one cycle.

Test Plan:
- Home (1,1,1), CELLS=4: send gcid (0,1,2) → accepted, o_nb_slot = 0*9+1*3+2 = 5, o_accept_cnt = 1. Send (3,1,1) → dropped, o_drop_cnt = 1.
- Wrap: home (0,0,0); send (3,3,3) → slot 0; send (1,0,0) → slot 22; send (2,0,0) → dropped.
- Backpressure: FIFO_DEPTH=16, i_ready=0, push 16 valid neighbours → o_ready falls after the 16th handshake and the 17th packet stalls. Raise i_ready for 1 cycle → o_ready returns the next cycle and the 17th is accepted. Output order matches input order.
- Completion: i_src_done bits pulsed in 3 separate cycles covering 0xFF, with 2 entries buffered → RECV→DRAIN. After 2 pops → DONE, o_iter_done high for exactly 1 cycle, then IDLE.
- Reset while in RECV with 5 entries buffered → next cycle o_valid=0, o_ready=0, counters 0, state IDLE. A new i_PE_start restarts cleanly.
- Counter saturation: 65540 dropped packets → o_drop_cnt holds at 0xFFFF. A new i_PE_start clears it to 0.

Source files
------------

// File: rtl/pos_pkt_receiver.sv
// pos_pkt_receiver
//   Consumer end of the position-cache broadcast stream, one per home cell.
//   Packets whose source cell lies in the home cell's 27-cell neighbourhood
//   (with wrap-around) are tagged with a neighbour slot 0..26 and buffered in
//   a show-ahead FIFO. All other packets are dropped and counted. Once every
//   source has reported done and the FIFO has drained, o_iter_done pulses.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   i_PE_start       one-cycle pulse that starts an iteration (IDLE only)
//   i_home_gcid      home cell {x,y,z}, static during an iteration
//   i_pos_pkt        incoming position packet
//   i_cur_gcid       source cell {x,y,z} of i_pos_pkt
//   i_valid/o_ready  input handshake
//   i_src_done       per-source "finished streaming" pulses
//   o_pkt/o_nb_slot  FIFO head packet and its neighbour slot
//   o_valid/i_ready  output handshake
//   o_iter_done      one-cycle pulse at iteration end
//   o_accept_cnt     packets accepted this iteration (saturating)
//   o_drop_cnt       packets dropped this iteration (saturating)
//   o_debug_state    FSM state: 0 IDLE, 1 RECV, 2 DRAIN, 3 DONE
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   The producer holds data stable while valid is high and ready is low.
//   o_ready depends only on registered state, never on i_valid. o_valid
//   depends only on FIFO occupancy, never on i_ready.
module pos_pkt_receiver #(
  parameter int PKT_WIDTH  = 64,
  parameter int GCID_WIDTH = 3,
  parameter int CELLS_X    = 4,
  parameter int CELLS_Y    = 4,
  parameter int CELLS_Z    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_SRC    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_PE_start,
  input  logic [3*GCID_WIDTH-1:0] i_home_gcid,
  input  logic [PKT_WIDTH-1:0]    i_pos_pkt,
  input  logic [3*GCID_WIDTH-1:0] i_cur_gcid,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NUM_SRC-1:0]      i_src_done,
  output logic [PKT_WIDTH-1:0]    o_pkt,
  output logic [4:0]              o_nb_slot,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_iter_done,
  output logic [15:0]             o_accept_cnt,
  output logic [15:0]             o_drop_cnt,
  output logic [1:0]              o_debug_state
);

  localparam int GW = GCID_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = PKT_WIDTH + 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [NUM_SRC-1:0] done_mask;

  // Per-dimension neighbour test. Result bit 2 = is a neighbour, bits 1:0 =
  // offset + 1. d==1 is tested before d==cells-1 so that with two cells the
  // +1 mapping wins.
  function automatic logic [2:0] dim_map(input logic [GW-1:0] src,
                                         input logic [GW-1:0] home,
                                         input int            cells);
    logic [GW:0] diff;
    int          d;
    logic [2:0]  r;
    diff = {1'b0, src} - {1'b0, home};
    d    = int'(diff) % cells;
    if (d == 0)              r = 3'b101;
    else if (d == 1)         r = 3'b110;
    else if (d == cells - 1) r = 3'b100;
    else                     r = 3'b000;
    return r;
  endfunction

  logic [2:0]    map_x, map_y, map_z;
  logic          is_nb;
  logic [4:0]    slot;
  logic          full, empty;
  logic          hs, push, pop;
  logic [EW-1:0] head;

  assign map_x = dim_map(i_cur_gcid[3*GW-1:2*GW], i_home_gcid[3*GW-1:2*GW], CELLS_X);
  assign map_y = dim_map(i_cur_gcid[2*GW-1:GW],   i_home_gcid[2*GW-1:GW],   CELLS_Y);
  assign map_z = dim_map(i_cur_gcid[GW-1:0],      i_home_gcid[GW-1:0],      CELLS_Z);
  assign is_nb = map_x[2] & map_y[2] & map_z[2];
  assign slot  = {3'b0, map_x[1:0]} * 5'd9 + {3'b0, map_y[1:0]} * 5'd3
               + {3'b0, map_z[1:0]};

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign o_ready = (state == RECV) && !full;
  assign hs      = i_valid && o_ready;
  assign push    = hs && is_nb;
  assign pop     = !empty && i_ready;

  // Head is forced to zero while empty so the outputs read 0 after reset
  // even though the storage itself is not reset.
  assign head          = mem[rd_ptr];
  assign o_valid       = !empty;
  assign o_pkt         = empty ? '0 : head[EW-1:5];
  assign o_nb_slot     = empty ? '0 : head[4:0];
  assign o_debug_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_pos_pkt, slot};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      done_mask    <= '0;
      o_accept_cnt <= '0;
      o_drop_cnt   <= '0;
      o_iter_done  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (hs) begin
        if (is_nb) begin
          if (o_accept_cnt != 16'hFFFF) o_accept_cnt <= o_accept_cnt + 16'd1;
        end else begin
          if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
      end

      o_iter_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_PE_start) begin
            state        <= RECV;
            done_mask    <= '0;
            o_accept_cnt <= '0;
            o_drop_cnt   <= '0;
          end
        end
        RECV: begin
          done_mask <= done_mask | i_src_done;
          if ((done_mask | i_src_done) == {NUM_SRC{1'b1}}) state <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            state       <= DONE;
            o_iter_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
